// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, issues imem requests and arbitrates
// sequential, branch, trap and stall updates. All outputs are registered.
module pc_sequencer #(
  parameter int unsigned      DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  trap_req,
  input  logic [DATA_WIDTH-1:0] trap_vector,
  input  logic                  imem_ready,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_pc,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {StBoot, StFetch, StStall} state_e;

  state_e state_q;

  logic [DATA_WIDTH-1:0] trap_pc;
  logic                  target_ok;

  assign trap_pc   = {trap_vector[DATA_WIDTH-1:2], 2'b00};
  assign target_ok = (branch_target[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StBoot;
      pc           <= RESET_VECTOR;
      fetch_pc     <= '0;
      imem_req     <= 1'b0;
      fetch_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      fetch_valid  <= 1'b0;
      misalign_err <= 1'b0;
      case (state_q)
        StBoot: begin
          state_q  <= StFetch;
          imem_req <= 1'b1;
        end
        StFetch: begin
          // Any redirect or stall cancels a handshake landing in the same cycle.
          if (trap_req) begin
            pc <= trap_pc;
          end else if (branch_taken) begin
            if (target_ok) pc <= branch_target;
            else           misalign_err <= 1'b1;
          end else if (stall) begin
            state_q  <= StStall;
            imem_req <= 1'b0;
          end else if (imem_ready) begin
            pc          <= pc + DATA_WIDTH'(4);
            fetch_pc    <= pc;
            fetch_valid <= 1'b1;
          end
        end
        StStall: begin
          if (trap_req) begin
            pc       <= trap_pc;
            state_q  <= StFetch;
            imem_req <= 1'b1;
          end else if (branch_taken) begin
            if (target_ok) pc <= branch_target;
            else           misalign_err <= 1'b1;
            state_q  <= StFetch;
            imem_req <= 1'b1;
          end else if (!stall) begin
            state_q  <= StFetch;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state_q  <= StBoot;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random traffic,
// all compared against a rule-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, trap_req = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = '0, trap_vector = '0;
  logic        imem_req, fetch_valid, misalign_err;
  logic [31:0] pc, fetch_pc;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  bit          m_boot, m_halted, m_fv, m_me;
  logic [31:0] m_pc, m_fpc;

  pc_sequencer #(
    .DATA_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .trap_req     (trap_req),
    .trap_vector  (trap_vector),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, !m_boot && !m_halted});
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_fv});
    chk({tag, ".fetch_pc"}, fetch_pc, m_fpc);
    chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, m_me});
  endtask

  task automatic model_reset();
    m_boot = 1; m_halted = 0; m_fv = 0; m_me = 0;
    m_pc = 32'h0; m_fpc = 32'h0;
  endtask

  // One clock of the reference rules, using the inputs presented before the edge.
  task automatic model_step();
    bit redirected;
    m_fv = 0; m_me = 0; redirected = 0;
    if (m_boot) begin
      m_boot = 0;
    end else begin
      if (trap_req) begin
        m_pc = trap_vector & ~32'd3;
        redirected = 1;
      end else if (branch_taken) begin
        if (branch_target % 4 == 0) m_pc = branch_target;
        else m_me = 1;
        redirected = 1;
      end
      if (m_halted) begin
        if (redirected || !stall) m_halted = 0;
      end else if (!redirected) begin
        if (stall) m_halted = 1;
        else if (imem_ready) begin
          m_fpc = m_pc;
          m_pc  = m_pc + 32'd4;
          m_fv  = 1;
        end
      end
    end
  endtask

  task automatic cyc(input string tag, input logic st, input logic br, input logic [31:0] bt,
                     input logic tr, input logic [31:0] tv, input logic rdy);
    stall = st; branch_taken = br; branch_target = bt;
    trap_req = tr; trap_vector = tv; imem_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    chk_all(tag);
  endtask

  initial begin
    // T1 reset
    model_reset();
    #12;
    chk_all("reset_hold");
    rst = 1'b1;
    #1;
    chk_all("reset_release");
    cyc("boot", 0, 0, 0, 0, 0, 0);
    cyc("t1_wait", 0, 0, 0, 0, 0, 0);
    // T2 streaming
    for (int i = 0; i < 4; i++) cyc("t2_stream", 0, 0, 0, 0, 0, 1);
    chk("t2_pc_0x10", pc, 32'h10);
    chk("t2_fetch_pc_c", fetch_pc, 32'hC);
    // T3 branch from 0x10 (same rules as at 0x8)
    cyc("t3_branch", 0, 1, 32'h100, 0, 0, 1);
    chk("t3_pc_0x100", pc, 32'h100);
    cyc("t3_fetch", 0, 0, 0, 0, 0, 1);
    chk("t3_fetch_pc_0x100", fetch_pc, 32'h100);
    cyc("t3_misalign", 0, 1, 32'h102, 0, 0, 1);
    chk("t3_misalign_pulse", {31'd0, misalign_err}, 32'd1);
    cyc("t3_after", 0, 0, 0, 0, 0, 0);
    // T4 stall at 0x20
    cyc("t4_goto", 0, 1, 32'h20, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t4_stall", 1, 0, 0, 0, 0, 1);
    chk("t4_pc_held", pc, 32'h20);
    cyc("t4_release", 0, 0, 0, 0, 0, 1);
    cyc("t4_fetch", 0, 0, 0, 0, 0, 1);
    chk("t4_fetch_pc_0x20", fetch_pc, 32'h20);
    // T5 priority
    cyc("t5_all", 1, 1, 32'h200, 1, 32'h83, 1);
    chk("t5_pc_0x80", pc, 32'h80);
    cyc("t5_stall", 1, 0, 0, 0, 0, 0);
    cyc("t5_stall_trap", 1, 1, 32'h40, 1, 32'h80, 0);
    cyc("t5_stall_br_mis", 1, 0, 0, 0, 0, 0);
    cyc("t5_stall_br", 1, 1, 32'h41, 0, 0, 1);
    // T6 wrap and async reset mid-wait
    cyc("t6_goto", 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cyc("t6_wrap", 0, 0, 0, 0, 0, 1);
    chk("t6_pc_0", pc, 32'h0);
    cyc("t6_wait", 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk_all("t6_async_reset");
    #10;
    rst = 1'b1;
    cyc("t6_boot", 0, 0, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, tv;
      bt = $urandom;
      if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
      tv = $urandom;
      cyc("random", ($urandom_range(3) == 0), ($urandom_range(7) == 0), bt,
          ($urandom_range(15) == 0), tv, ($urandom_range(3) != 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
